// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: turns CPU pixel, fill and swap commands
// into one-pixel-per-cycle framebuffer writes and vsync-aligned swaps.
//
// Ports:
//   CLK, RESET             clock, async active-high reset
//   CMD_VALID/CMD_READY    command handshake (ready only when idle)
//   CMD_ADDR[11:0]         pixel index
//   CMD_DATA[6:0]          [6]=swap, [6:5]=01 fill, 00 pixel; [2:0] colour
//   VSYNC                  active-low vsync, asynchronous to CLK
//   FB_WE/WADDR/WDATA      framebuffer write port
//   FB_WSEL, DISP_SEL      write-target and scan-out buffer selects
//   SWAP_DONE              one-cycle pulse on each buffer swap
//   OOB_ERR                sticky: an out-of-range pixel write was dropped
module fb_write_scheduler #(
    parameter int FB_WIDTH  = 64,
    parameter int FB_HEIGHT = 48
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [11:0] CMD_ADDR,
    input  logic [6:0]  CMD_DATA,
    input  logic        VSYNC,
    output logic        FB_WE,
    output logic [11:0] FB_WADDR,
    output logic [2:0]  FB_WDATA,
    output logic        FB_WSEL,
    output logic        DISP_SEL,
    output logic        SWAP_DONE,
    output logic        OOB_ERR
);

    localparam int          FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam logic [11:0] LAST_ADDR = 12'(FB_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL,
        SWAP_WAIT
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        vs_s1;
    logic        vs_s2;
    logic        vs_d;
    logic        vs_fall;

    logic [11:0] addr_q;
    logic [2:0]  color_q;
    logic        pix_oob;
    logic [11:0] fill_cnt;
    logic        disp_q;
    logic        swap_done_q;
    logic        oob_q;

    logic        accept;
    logic        cmd_swap;
    logic        cmd_fill;
    logic        cmd_pix;
    logic        cmd_oob;
    logic        fill_last;
    logic        swap_fire;

    logic        unused_bits;
    assign unused_bits = ^CMD_DATA[4:3];

    // vs_d holds the previous synchronized level for edge detection
    assign vs_fall   = vs_d & ~vs_s2;

    assign accept    = CMD_VALID && (state == IDLE);
    assign cmd_swap  = CMD_DATA[6];
    assign cmd_fill  = ~CMD_DATA[6] & CMD_DATA[5];
    assign cmd_pix   = ~CMD_DATA[6] & ~CMD_DATA[5];
    assign cmd_oob   = {20'd0, CMD_ADDR} >= 32'(FB_DEPTH);
    assign fill_last = (fill_cnt == LAST_ADDR);
    // only edges seen while waiting count; one already past is ignored
    assign swap_fire = (state == SWAP_WAIT) && vs_fall;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        CMD_READY = 1'b0;
        FB_WE     = 1'b0;
        FB_WADDR  = addr_q;
        FB_WDATA  = color_q;
        case (state)
            IDLE: begin
                CMD_READY = 1'b1;
                if (accept) begin
                    if (cmd_swap) begin
                        state_nx = SWAP_WAIT;
                    end else if (cmd_fill) begin
                        state_nx = FILL;
                    end else begin
                        state_nx = WRITE;
                    end
                end
            end
            WRITE: begin
                FB_WE    = ~pix_oob;
                state_nx = IDLE;
            end
            FILL: begin
                FB_WE    = 1'b1;
                FB_WADDR = fill_cnt;
                if (fill_last) begin
                    state_nx = IDLE;
                end
            end
            SWAP_WAIT: begin
                if (vs_fall) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vs_s1       <= 1'b1;
            vs_s2       <= 1'b1;
            vs_d        <= 1'b1;
            addr_q      <= '0;
            color_q     <= '0;
            pix_oob     <= 1'b0;
            fill_cnt    <= '0;
            disp_q      <= 1'b0;
            swap_done_q <= 1'b0;
            oob_q       <= 1'b0;
        end else begin
            vs_s1       <= VSYNC;
            vs_s2       <= vs_s1;
            vs_d        <= vs_s2;
            swap_done_q <= swap_fire;
            if (swap_fire) begin
                disp_q <= ~disp_q;
            end
            if (accept && !cmd_swap) begin
                addr_q   <= CMD_ADDR;
                color_q  <= CMD_DATA[2:0];
                pix_oob  <= cmd_pix & cmd_oob;
                fill_cnt <= '0;
            end
            if (accept && cmd_pix && cmd_oob) begin
                oob_q <= 1'b1;
            end
            // counter parks on the last address instead of wrapping
            if (state == FILL && !fill_last) begin
                fill_cnt <= fill_cnt + 12'd1;
            end
        end
    end

    assign DISP_SEL  = disp_q;
    assign FB_WSEL   = ~disp_q;
    assign SWAP_DONE = swap_done_q;
    assign OOB_ERR   = oob_q;

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 Parameter FB_WIDTH, default 64, framebuffer width in pixels.
REQ-002 Parameter FB_HEIGHT, default 48, framebuffer height in pixels; FB_DEPTH = FB_WIDTH*FB_HEIGHT (3072).
REQ-003 Port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 Port RESET  input  1  asynchronous, active-high reset.
REQ-005 Port CMD_VALID  input  1  command strobe from the CPU bus interface.
REQ-006 Port CMD_READY  output  1  high when a command can be accepted this cycle.
REQ-007 Port CMD_ADDR  input  12  pixel index, already offset to 0-based.
REQ-008 Port CMD_DATA  input  7  command/data byte.
REQ-009 Port VSYNC  input  1  active-low vertical sync from the timing generator, asynchronous to CLK.
REQ-010 Port FB_WE  output  1  framebuffer write enable, one pixel per cycle.
REQ-011 Port FB_WADDR  output  12  framebuffer write address.
REQ-012 Port FB_WDATA  output  3  pixel colour {B,G,R}.
REQ-013 Port FB_WSEL  output  1  target buffer for writes; always ~DISP_SEL.
REQ-014 Port DISP_SEL  output  1  buffer being scanned out (0 = front, 1 = back).
REQ-015 Port SWAP_DONE  output  1  one-cycle pulse when DISP_SEL toggles.
REQ-016 Port OOB_ERR  output  1  sticky flag: a pixel write with CMD_ADDR >= FB_DEPTH was dropped.

Function
REQ-017 Command accepted on a rising edge where CMD_VALID && CMD_READY; CMD_READY SHALL be 1 only in state IDLE.
REQ-018 Decode: CMD_DATA[6]=1 -> SWAP; CMD_DATA[6:5]=01 -> FILL with colour CMD_DATA[2:0]; CMD_DATA[6:5]=00 -> PIXEL with colour CMD_DATA[2:0].
REQ-019 States: IDLE, WRITE, FILL, SWAP_WAIT; encoding is free.
REQ-020 IDLE: PIXEL -> WRITE; FILL -> FILL; SWAP -> SWAP_WAIT; no command -> stay.
REQ-021 PIXEL write latency: FB_WE=1 for exactly one cycle, the cycle after acceptance, with FB_WADDR=CMD_ADDR and FB_WDATA=colour; WRITE -> IDLE unconditionally.
REQ-022 PIXEL with CMD_ADDR >= FB_DEPTH: no FB_WE; OOB_ERR set to 1; WRITE still entered for one cycle and returns to IDLE.
REQ-023 FILL: FB_WE=1 on FB_DEPTH consecutive cycles starting the cycle after acceptance; FB_WADDR = 0,1,...,FB_DEPTH-1; FB_WDATA constant = latched colour; -> IDLE after address FB_DEPTH-1.
REQ-024 Fill counter SHALL be 12 bits and SHALL NOT wrap past FB_DEPTH-1.
REQ-025 VSYNC SHALL pass through a 2-flop synchronizer; a vsync start is a synchronized 1->0 transition.
REQ-026 SWAP_WAIT: on the first vsync start detected while in SWAP_WAIT (not one already in progress at entry), toggle DISP_SEL, pulse SWAP_DONE in that same cycle, -> IDLE.
REQ-027 VSYNC already low on entry to SWAP_WAIT SHALL NOT trigger a swap; wait for the next 1->0 edge.
REQ-028 FB_WE SHALL be 0 in IDLE and SWAP_WAIT; FB_WADDR/FB_WDATA are don't-care when FB_WE=0.
REQ-029 Commands are never queued; CMD_VALID while CMD_READY=0 is ignored with no side effect.
REQ-030 FB_WSEL SHALL change only in the swap cycle, never during WRITE or FILL.

Reset
REQ-031 RESET=1 SHALL immediately force: state IDLE, CMD_READY=1 after release, FB_WE=0, FB_WADDR=0, FB_WDATA=0, DISP_SEL=0, FB_WSEL=1, SWAP_DONE=0, OOB_ERR=0, synchronizer flops=1, fill counter=0.
REQ-032 RESET during FILL or SWAP_WAIT SHALL abort the operation; no further FB_WE or swap occurs after release.
REQ-033 OOB_ERR SHALL be cleared only by RESET.

Verification
REQ-034 PIXEL CMD_ADDR=0x0A5, CMD_DATA=0x05 -> next cycle FB_WE=1, FB_WADDR=0x0A5, FB_WDATA=3'b101, FB_WSEL=1; CMD_READY low for 1 cycle.
REQ-035 FILL CMD_DATA=0x23 -> 3072 FB_WE cycles, addresses 0..3071, FB_WDATA=3'b011, CMD_READY low for 3072 cycles, no write to 3072.
REQ-036 SWAP CMD_DATA=0x40 with VSYNC high, VSYNC falls 100 cycles later -> DISP_SEL 0->1, FB_WSEL 1->0, single SWAP_DONE pulse 3 cycles after the fall (2 sync + edge detect).
REQ-037 SWAP issued while VSYNC already low -> no swap until VSYNC rises then falls again.
REQ-038 PIXEL CMD_ADDR=0xC00 -> no FB_WE, OOB_ERR=1 and held through later valid commands.
REQ-039 RESET asserted at fill address 1000 -> FB_WE=0 immediately, all outputs at reset values, CMD_READY=1 after release, no further writes.
